// File: rtl/busca_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word and PC step.
package busca_pkg;

    typedef enum logic [1:0] {
        VAZIO  = 2'd0,
        CHEIO  = 2'd1,
        PARADO = 2'd2
    } estado_t;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] PASSO_PC = 32'd4;

endpackage

// File: rtl/memoria_instrucao.sv
// Word-addressed instruction memory: one write port, one synchronous read port.
// Latency: read data registered one edge after i_leitura_en; read-before-write on a shared index.
// Backpressure: none; the read register holds whenever i_leitura_en is low.
module memoria_instrucao #(
    parameter int LARGURA      = 32,
    parameter int PROFUNDIDADE = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_leitura_en,
    input  logic [$clog2(PROFUNDIDADE)-1:0] i_leitura_end,
    output logic [LARGURA-1:0]              o_leitura_dado,
    input  logic                            i_escrita_en,
    input  logic [$clog2(PROFUNDIDADE)-1:0] i_escrita_end,
    input  logic [LARGURA-1:0]              i_escrita_dado
);

    logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
    logic [LARGURA-1:0] r_dado;

    // The array is never reset; only the read register clears with rst.
    always_ff @(posedge i_clk) begin
        if (i_escrita_en) begin
            r_mem[i_escrita_end] <= i_escrita_dado;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dado <= '0;
        end else if (i_leitura_en) begin
            r_dado <= r_mem[i_leitura_end];
        end
    end

    assign o_leitura_dado = r_dado;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch: owns pc_busca, instruction memory with load port, registered output to decode; BUSCA_FALHA_EN adds a fetch-address fault check.
// Latency: valido one edge after a fetch; redirect target valid two edges after desvio.
// Backpressure: output held while valido && !pronto; a faulted output is held until desvio or rst.
module busca_instrucao
    import busca_pkg::*;
#(
    parameter int          LARGURA      = 32,
    parameter int          PROFUNDIDADE = 64,
    parameter logic [31:0] PC_INICIAL   = 32'h0
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_pronto,
    input  logic                            i_desvio,
    input  logic [31:0]                     i_alvo_desvio,
    input  logic                            i_escrita_en,
    input  logic [$clog2(PROFUNDIDADE)-1:0] i_escrita_end,
    input  logic [LARGURA-1:0]              i_escrita_dado,
    output logic                            o_valido,
    output logic [LARGURA-1:0]              o_instrucao,
    output logic [31:0]                     o_pc_instrucao,
    output logic                            o_falha
);

    localparam int IW = $clog2(PROFUNDIDADE);

    estado_t            r_estado;
    estado_t            w_prox_estado;
    logic [31:0]        r_pc_busca;
    logic [31:0]        r_pc_instrucao;
    logic [LARGURA-1:0] w_mem_dado;
    logic               w_avanca;
    logic               w_carrega;
    logic               w_busca;
    logic               w_falha_end;

    assign w_avanca  = (r_estado == VAZIO) || i_pronto;
    // w_carrega loads the output register (good fetch or faulted NOP); w_busca only for a good fetch.
    assign w_carrega = !i_desvio && w_avanca && (r_estado != PARADO);
    assign w_busca   = w_carrega && !w_falha_end;

`ifdef BUSCA_FALHA_EN
    assign w_falha_end = (r_pc_busca[1:0] != 2'b00) ||
                         ({2'b00, r_pc_busca[31:2]} >= 32'(PROFUNDIDADE));
`else
    assign w_falha_end = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_estado <= VAZIO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        if (i_desvio) begin
            w_prox_estado = VAZIO;
        end else if (w_carrega) begin
            w_prox_estado = w_falha_end ? PARADO : CHEIO;
        end
    end

    always_comb begin
        o_valido       = (r_estado != VAZIO);
        o_pc_instrucao = r_pc_instrucao;
`ifdef BUSCA_FALHA_EN
        o_falha        = (r_estado == PARADO);
        o_instrucao    = (r_estado == PARADO) ? LARGURA'(NOP) : w_mem_dado;
`else
        o_falha        = 1'b0;
        o_instrucao    = w_mem_dado;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc_busca     <= PC_INICIAL;
            r_pc_instrucao <= 32'h0;
        end else begin
            if (i_desvio) begin
                r_pc_busca <= i_alvo_desvio;
            end else if (w_busca) begin
                r_pc_busca <= r_pc_busca + PASSO_PC;
            end
            if (w_carrega) begin
                r_pc_instrucao <= r_pc_busca;
            end
        end
    end

    memoria_instrucao #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_memoria (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_leitura_en   (w_busca),
        .i_leitura_end  (r_pc_busca[IW+1:2]),
        .o_leitura_dado (w_mem_dado),
        .i_escrita_en   (i_escrita_en),
        .i_escrita_end  (i_escrita_end),
        .i_escrita_dado (i_escrita_dado)
    );

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed redirect/stall/load/wrap/reset scenarios against a transaction-level fetch model.
module tb_busca_instrucao;

    localparam int PROF = 64;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        pronto     = 1'b0;
    logic        desvio     = 1'b0;
    logic [31:0] alvo       = 32'h0;
    logic        escrita_en = 1'b0;
    logic [5:0]  esc_end    = 6'd0;
    logic [31:0] esc_dado   = 32'h0;

    logic        o_valido;
    logic [31:0] o_instrucao;
    logic [31:0] o_pc_instrucao;
    logic        o_falha;

    busca_instrucao #(
        .LARGURA      (32),
        .PROFUNDIDADE (PROF),
        .PC_INICIAL   (32'h0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pronto       (pronto),
        .i_desvio       (desvio),
        .i_alvo_desvio  (alvo),
        .i_escrita_en   (escrita_en),
        .i_escrita_end  (esc_end),
        .i_escrita_dado (esc_dado),
        .o_valido       (o_valido),
        .o_instrucao    (o_instrucao),
        .o_pc_instrucao (o_pc_instrucao),
        .o_falha        (o_falha)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int acc8  = 0;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [31:0] palavra(input int i);
        case (i)
            0:       return 32'h00611020;
            1:       return 32'h02723022;
            2:       return 32'hAD110064;
            3:       return 32'h00E84825;
            default: return 32'hC0DE_0000 | 32'(i);
        endcase
    endfunction

    function automatic bit faz_falha(input logic [31:0] pc);
`ifdef BUSCA_FALHA_EN
        return (pc[1:0] != 2'b00) || (pc[31:2] >= 30'(PROF));
`else
        return (pc == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Transaction model: what decode sees, derived from fetch/redirect/load rules.
    logic [31:0] mem_m [PROF];
    bit          m_valid = 1'b0;
    bit          m_falha = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] pc_m    = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_falha = 1'b0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            pc_m    = 32'h0;
        end else if (desvio) begin
            pc_m    = alvo;
            m_valid = 1'b0;
            m_falha = 1'b0;
        end else if (!m_falha && (!m_valid || pronto)) begin
            m_pc    = pc_m;
            m_valid = 1'b1;
            if (faz_falha(pc_m)) begin
                m_instr = 32'h0;
                m_falha = 1'b1;
            end else begin
                m_instr = mem_m[(pc_m >> 2) % PROF];
                pc_m    = pc_m + 32'd4;
            end
        end
        if (escrita_en) mem_m[esc_end] = esc_dado;
    end

    always @(negedge clk) begin
        chk("valido", 32'(o_valido), 32'(m_valid));
        chk("falha", 32'(o_falha), 32'(m_falha));
        if (m_valid) begin
            chk("pc_instrucao", o_pc_instrucao, m_pc);
            chk("instrucao", o_instrucao, m_instr);
        end
        if (o_valido && pronto && o_pc_instrucao == 32'd8) acc8++;
    end

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic ver(input string nome, input logic [31:0] pc, input logic [31:0] instr);
        chk({nome, "_valido"}, 32'(o_valido), 32'd1);
        chk({nome, "_pc"}, o_pc_instrucao, pc);
        chk({nome, "_instr"}, o_instrucao, instr);
    endtask

    initial begin
        // Load the whole memory while held in reset.
        for (int i = 0; i < PROF; i++) begin
            escrita_en = 1'b1;
            esc_end    = 6'(i);
            esc_dado   = palavra(i);
            edge_();
        end
        escrita_en = 1'b0;
        chk("rst_valido", 32'(o_valido), 32'd0);
        chk("rst_instr", o_instrucao, 32'h0);
        chk("rst_pc", o_pc_instrucao, 32'h0);
        chk("rst_falha", 32'(o_falha), 32'd0);

        rst = 1'b0; pronto = 1'b1;
        edge_(); ver("seq0", 32'd0,  32'h00611020);
        edge_(); ver("seq1", 32'd4,  32'h02723022);
        edge_(); ver("seq2", 32'd8,  32'hAD110064);
        edge_(); ver("seq3", 32'd12, 32'h00E84825);

        // Restart at 0, then stall on pc 4.
        desvio = 1'b1; alvo = 32'd0;
        edge_(); chk("desvio0_valido", 32'(o_valido), 32'd0);
        desvio = 1'b0;
        edge_(); ver("re0", 32'd0, 32'h00611020);
        edge_(); ver("re4", 32'd4, 32'h02723022);
        pronto = 1'b0;
        for (int k = 0; k < 3; k++) begin
            edge_(); ver("stall", 32'd4, 32'h02723022);
        end
        // Overwrite word 2 on the very edge that fetches pc 8.
        pronto = 1'b1; escrita_en = 1'b1; esc_end = 6'd2; esc_dado = 32'hFFFF_FFFF;
        edge_(); ver("rbw_old", 32'd8, 32'hAD110064);
        escrita_en = 1'b0;

        // Redirect to 20 while pc 8 is held unaccepted.
        pronto = 1'b0; desvio = 1'b1; alvo = 32'd20; acc8 = 0;
        edge_(); chk("desvio20_valido", 32'(o_valido), 32'd0);
        desvio = 1'b0;
        edge_(); ver("alvo20", 32'd20, palavra(5));
        chk("pc8_nao_aceito", 32'(acc8), 32'd0);

        pronto = 1'b1; desvio = 1'b1; alvo = 32'd8;
        edge_(); chk("desvio8_valido", 32'(o_valido), 32'd0);
        desvio = 1'b0;
        edge_(); ver("rbw_new", 32'd8, 32'hFFFF_FFFF);

        // Back-to-back redirects: the last target wins.
        desvio = 1'b1; alvo = 32'd40;
        edge_(); chk("b2b_1_valido", 32'(o_valido), 32'd0);
        alvo = 32'd12;
        edge_(); chk("b2b_2_valido", 32'(o_valido), 32'd0);
        desvio = 1'b0;
        edge_(); ver("b2b_alvo", 32'd12, 32'h00E84825);
        edge_(); ver("b2b_prox", 32'd16, palavra(4));

        // Run off the end of the memory.
        desvio = 1'b1; alvo = 32'd248;
        edge_();
        desvio = 1'b0;
        edge_(); ver("fim248", 32'd248, palavra(62));
        edge_(); ver("fim252", 32'd252, palavra(63));
        edge_();
`ifdef BUSCA_FALHA_EN
        ver("fim256", 32'd256, 32'h0);
        chk("fim256_falha", 32'(o_falha), 32'd1);
        edge_(); ver("fim256_preso", 32'd256, 32'h0);
        chk("fim256_preso_falha", 32'(o_falha), 32'd1);
`else
        ver("fim256", 32'd256, 32'h00611020);
        chk("fim256_falha", 32'(o_falha), 32'd0);
        edge_(); ver("fim260", 32'd260, 32'h02723022);
`endif
        desvio = 1'b1; alvo = 32'd0;
        edge_();
        desvio = 1'b0;
        edge_(); ver("volta0", 32'd0, 32'h00611020);
        chk("volta0_falha", 32'(o_falha), 32'd0);

        // Asynchronous reset in the middle of a cycle.
        edge_(); ver("pre_rst", 32'd4, 32'h02723022);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valido", 32'(o_valido), 32'd0);
        chk("arst_instr", o_instrucao, 32'h0);
        chk("arst_pc", o_pc_instrucao, 32'h0);
        chk("arst_falha", 32'(o_falha), 32'd0);
        edge_();
        edge_();
        rst = 1'b0;
        edge_(); ver("pos_rst0", 32'd0, 32'h00611020);
        edge_(); ver("pos_rst4", 32'd4, 32'h02723022);
        edge_();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Parametrised instruction-fetch stage for the MIPS processor: owns the fetch PC, holds a word-addressed instruction memory with a load port, and delivers one instruction per cycle to decode over a valid/ready handshake. It supports redirects with flush for branches and jumps, and an optional fault check on the fetch address. It sits between the PC/branch logic and the decode stage.

## Interface
- `LARGURA`, 32: instruction word width in bits.
- `PROFUNDIDADE`, 64: memory depth in words; must be a power of two, at least 2.
- `PC_INICIAL`, 32'h0: fetch PC after reset; byte address, word-aligned.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `pronto`  in  1  decode accepts the current instruction this cycle.
- `desvio`  in  1  redirect request; one-cycle pulse.
- `alvo_desvio`  in  32  redirect target, byte address.
- `escrita_en`  in  1  memory load strobe.
- `escrita_end`  in  log2(PROFUNDIDADE)  word index to load.
- `escrita_dado`  in  LARGURA  word to load.
- `valido`  out  1  `instrucao` and `pc_instrucao` hold a valid fetch.
- `instrucao`  out  LARGURA  fetched instruction, registered.
- `pc_instrucao`  out  32  byte address of `instrucao`.
- `falha`  out  1  the current output is a faulted fetch.

## Operation
- Internal `pc_busca` is the 32-bit byte address of the next fetch. The word index is `pc_busca[log2(PROFUNDIDADE)+1:2]`.
- States:
  - VAZIO: output register empty.
  - CHEIO: output register holds a valid instruction.
  - PARADO: a faulted output is held and fetch is halted.
- `avanca = !valido || pronto`. On an edge with `avanca` and no `desvio`, in VAZIO or CHEIO:
  - `instrucao <= Memoria[idx]`, `pc_instrucao <= pc_busca`, `valido <= 1`.
  - `pc_busca <= pc_busca + 4`, wrapping modulo 2^32.
  - Next state is CHEIO.
- In CHEIO with `pronto = 0`, all outputs hold stable.
- `desvio` has priority over everything else:
  - `pc_busca <= alvo_desvio`, `valido <= 0`, `falha <= 0`, next state VAZIO.
  - A handshake completing in the same cycle (`valido && pronto`) counts as consumed. Without `pronto`, the held instruction is discarded.
- Load port:
  - `escrita_en` writes `Memoria[escrita_end]` on the edge.
  - A same-edge fetch of the same index returns the old word (read-before-write).
  - Loads are accepted in every state.
- Memory contents are undefined after power-up and are not affected by `rst`.

## Timing
- On `rst`: `valido = 0`, `instrucao = 0`, `pc_instrucao = 0`, `falha = 0`, `pc_busca = PC_INICIAL`, state VAZIO.
- Reset mid-stream drops the held instruction immediately, without waiting for an edge.
- First fetch: first edge after `rst` deasserts; `valido` is high after that edge.
- Throughput: 1 instruction/cycle while `pronto = 1`.
- Redirect latency:
  - `desvio` sampled at edge N gives `valido = 0` after edge N.
  - The target instruction is valid after edge N+1.
- Back-to-back `desvio` pulses: the last one wins; `valido` stays 0 until one edge after the last pulse.

## Configuration
- `BUSCA_FALHA_EN` defined:
  - If `pc_busca[1:0] != 0` or the word address is at or above `PROFUNDIDADE`, the fetch edge loads `instrucao = 0` (NOP), `pc_instrucao = pc_busca`, `valido = 1`, `falha = 1`.
  - `pc_busca` is not incremented; state goes to PARADO.
  - In PARADO the output holds through `pronto`: `valido` stays 1 and no new fetch occurs.
  - Only `desvio` or `rst` leaves PARADO.
- `BUSCA_FALHA_EN` undefined:
  - Address bits [1:0] are ignored and the index wraps modulo `PROFUNDIDADE`.
  - `falha` is tied to 0 and PARADO is unreachable.

## Structure
- Package `busca_pkg` holds:
  - the state encoding: VAZIO, CHEIO, PARADO;
  - `NOP` = 32'h0000_0000;
  - the PC step constant, 4.
- Sub-module `memoria_instrucao`: synchronous-read memory with one write port, parametrised by `LARGURA` and `PROFUNDIDADE`. The fetch FSM, PC and output register stay in `busca_instrucao`.

## Test plan
- Load words 0..3 with 32'h00611020, 32'h02723022, 32'hAD110064, 32'h00E84825; release `rst` with `pronto = 1` -> consecutive `pc_instrucao` 0, 4, 8, 12 with matching `instrucao`, one per cycle.
- Hold `pronto = 0` for 3 cycles while showing pc 4 -> outputs are stable; when `pronto` rises, pc 8 follows on the next edge with no skip and no duplicate.
- Pulse `desvio` with `alvo_desvio = 20` while showing pc 8 and `pronto = 0` -> `valido = 0` for one cycle, then pc 20; pc 8 is never accepted.
- Write word 2 with 32'hFFFF_FFFF on the same edge as the fetch of pc 8 -> output is the old 32'hAD110064; a later redirect to 8 returns 32'hFFFF_FFFF.
- With `BUSCA_FALHA_EN` and `PROFUNDIDADE = 64`, run to pc 252 -> pc 256 shows `falha = 1`, `instrucao = 0`, and is held through `pronto`; a `desvio` to 0 clears `falha`. Without the macro, pc 256 returns word 0.
- Assert `rst` while `valido = 1` in the middle of a cycle -> all outputs are 0 immediately; after release, the fetch restarts at `PC_INICIAL`.
